// File: rtl/sine_gen_defs.sv
// Definitions shared by the sine-generator blocks.
package sine_gen_defs;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } seq_state_t;

    localparam int LUT_IDX_W = 6;

    // Phase 0 of the LUT is the midscale sample.
    localparam logic [LUT_IDX_W-1:0] MIDSCALE_IDX = 6'd0;

endpackage

// File: rtl/sine_phase_sequencer_phase_accumulator.sv
// Registered phase accumulator with clear/enable; the carry is the period wrap.
module phase_accumulator #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic [ACC_W-1:0] acc,
    output logic             carry
);

    logic [ACC_W-1:0] sum;

    // Carry is combinational so the controller can act on the wrapping edge.
    always_comb begin
        {carry, sum} = {1'b0, acc} + {1'b0, inc};
    end

    // Clear wins over enable so a run end parks the phase at 0, not the wrapped value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= sum;
    end

endmodule

// File: rtl/sine_phase_sequencer.sv
// Run controller for the sine LUT index: config handshake, period counting, graceful stop.
module sine_phase_sequencer
    import sine_gen_defs::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_W-1:0]     cfg_inc,
    input  logic [CNT_W-1:0]     cfg_cycles,
    input  logic                 start,
    input  logic                 stop,
    output logic [LUT_IDX_W-1:0] lut_idx,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 wave_done
);

    seq_state_t       state, state_nxt;
    logic [ACC_W-1:0] inc_reg;
    logic [CNT_W-1:0] cycles_reg;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] per_cnt_inc;
    logic [ACC_W-1:0] acc;
    logic             carry;
    logic             acc_clr, acc_en, cnt_clr, cnt_step, done_set;

    phase_accumulator #(.ACC_W(ACC_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .inc   (inc_reg),
        .acc   (acc),
        .carry (carry)
    );

    assign per_cnt_inc  = per_cnt + 1'b1;
    assign cfg_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign sample_valid = (state == RUN) || (state == STOPPING);
    assign lut_idx      = LUT_IDX_W'(acc >> (ACC_W - LUT_IDX_W));

    // Next-state and datapath controls; a wrap that ends the run clears the phase.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_step  = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                // Zero check uses the increment held before any same-edge config write.
                if (start && (inc_reg != '0)) begin
                    state_nxt = RUN;
                    acc_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                if (carry) begin
                    if (stop || ((cycles_reg != '0) && (per_cnt_inc == cycles_reg))) begin
                        state_nxt = IDLE;
                        acc_clr   = 1'b1;
                        done_set  = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end else if (stop) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                acc_en = 1'b1;
                if (carry) begin
                    state_nxt = IDLE;
                    acc_clr   = 1'b1;
                    done_set  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_clr   = 1'b1;
            end
        endcase
    end

    // State register and registered end-of-run pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wave_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wave_done <= done_set;
        end
    end

    // Config latch; only accepted while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_reg    <= '0;
            cycles_reg <= '0;
        end else if (cfg_valid && cfg_ready) begin
            inc_reg    <= cfg_inc;
            cycles_reg <= cfg_cycles;
        end
    end

    // Completed-period counter; wraps freely in continuous mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        per_cnt <= '0;
        else if (cnt_clr)  per_cnt <= '0;
        else if (cnt_step) per_cnt <= per_cnt_inc;
    end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Self-checking bench: directed and random runs against a closed-form sample model.
module tb_sine_phase_sequencer;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam longint FULL = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_inc = '0;
    logic [CNT_W-1:0] cfg_cycles = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [5:0]       lut_idx;
    logic             sample_valid;
    logic             busy;
    logic             wave_done;

    int vectors = 0;
    int miscompares = 0;

    sine_phase_sequencer #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_inc      (cfg_inc),
        .cfg_cycles   (cfg_cycles),
        .start        (start),
        .stop         (stop),
        .lut_idx      (lut_idx),
        .sample_valid (sample_valid),
        .busy         (busy),
        .wave_done    (wave_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".valid"}, longint'(sample_valid), 0);
        chk({tag, ".busy"},  longint'(busy), 0);
        chk({tag, ".ready"}, longint'(cfg_ready), 1);
        chk({tag, ".idx"},   longint'(lut_idx), 0);
        chk({tag, ".done"},  longint'(wave_done), longint'(exp_done));
    endtask

    // Sample k sits at phase k*inc mod 2^ACC_W; a run ends after the sample
    // that completes period W, i.e. after ceil(W*2^ACC_W/inc) samples.
    function automatic longint samples_for(input longint periods, input longint inc);
        return (periods * FULL + inc - 1) / inc;
    endfunction

    function automatic longint run_len(input longint inc, input longint cycles, input longint stop_at);
        longint n = 1 << 30;
        if (cycles != 0) n = samples_for(cycles, inc);
        if (stop_at >= 0 && stop_at < n)
            n = samples_for((stop_at * inc) / FULL + 1, inc);
        return n;
    endfunction

    // Configure, start, then follow the run sample by sample.
    // stop_at/poke_at < 0 disable the stop pulse / in-run config poke.
    task automatic run(input string tag, input longint inc, input longint cycles,
                       input longint stop_at, input longint poke_at);
        longint n = run_len(inc, cycles, stop_at);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_inc = ACC_W'(inc); cfg_cycles = CNT_W'(cycles);
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (longint k = 0; k < n; k++) begin
            chk($sformatf("%s.s%0d.valid", tag, k), longint'(sample_valid), 1);
            chk($sformatf("%s.s%0d.idx", tag, k), longint'(lut_idx),
                ((k * inc) % FULL) >> (ACC_W - 6));
            stop = (k == stop_at);
            if (k == poke_at) begin
                cfg_valid = 1'b1; cfg_inc = 16'd5; cfg_cycles = 8'd1;
                chk({tag, ".poke_ready"}, longint'(cfg_ready), 0);
            end else begin
                cfg_valid = 1'b0;
            end
            @(negedge clk);
        end
        stop = 1'b0; cfg_valid = 1'b0;
        chk_idle({tag, ".end"}, 1'b1);
        @(negedge clk);
        chk_idle({tag, ".after"}, 1'b0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk_idle("reset_held", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("reset", 1'b0);

        // start with inc_reg==0 is ignored even when config lands on the same edge
        cfg_valid = 1'b1; cfg_inc = 16'd1024; cfg_cycles = 8'd1; start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
        chk_idle("zero_inc_start", 1'b0);
        @(negedge clk);
        chk_idle("zero_inc_start2", 1'b0);

        // stop while idle does nothing
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_idle("idle_stop", 1'b0);

        run("finite2", 1024, 2, -1, -1);
        run("graceful", 3000, 0, 10, -1);
        run("stop_wrap", 16384, 0, 3, -1);
        run("cfg_busy", 1024, 1, -1, 30);
        run("finite1_odd", 5000, 1, -1, -1);

        // Random runs against the model
        for (int r = 0; r < 12; r++) begin
            longint inc = longint'($urandom_range(2000, 20000));
            longint cyc = longint'($urandom_range(0, 3));
            longint sa  = (cyc == 0) ? longint'($urandom_range(0, 30))
                                     : longint'($urandom_range(0, 120));
            run($sformatf("rnd%0d", r), inc, cyc, sa, -1);
        end

        // Async reset mid-run
        @(negedge clk);
        cfg_valid = 1'b1; cfg_inc = 16'd1024; cfg_cycles = 8'd0;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid.pre_idx", longint'(lut_idx), 20);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.valid", longint'(sample_valid), 0);
        chk("rst_mid.idx",   longint'(lut_idx), 0);
        chk("rst_mid.busy",  longint'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("rst_mid.after", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sine_phase_sequencer.md
Name: sine_phase_sequencer

Overview:
- Phase-accumulator (DDS-style) controller that drives the 6-bit sample index of the 64-entry sine LUT.
- Steps the index at a programmable rate.
- Runs either a fixed number of full periods or continuously.
- Stop is graceful: output is parked at phase 0 (midscale, LUT value 1000) on a period boundary, so the waveform never truncates mid-cycle.

Parameters:
ACC_W, 16, phase accumulator width; LUT index = acc[ACC_W-1:ACC_W-6]; must be >= 6
CNT_W, 8, width of period-count config and counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  config write request
cfg_ready  output  1  config accepted when high; equals (state==IDLE)
cfg_inc  input  ACC_W  phase increment per clock (frequency tuning word)
cfg_cycles  input  CNT_W  number of full periods per run; 0 = continuous
start  input  1  single-cycle run request
stop  input  1  single-cycle graceful stop request
lut_idx  output  6  index to sine LUT select input
sample_valid  output  1  lut_idx is a live sample this cycle
busy  output  1  state != IDLE
wave_done  output  1  one-cycle pulse when a run ends

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, acc=0, inc_reg=0, cycles_reg=0, per_cnt=0.
  - Outputs: lut_idx=0, sample_valid=0, busy=0, wave_done=0, cfg_ready=1.
- Reset mid-run aborts immediately; there is no drain.
- lut_idx is always the top 6 bits of the registered acc, combinational from the register. sample_valid=1 exactly when state is RUN or STOPPING.
- Config handshake:
  - Transfer happens on the clock where cfg_valid & cfg_ready; inc_reg and cycles_reg are latched on that edge.
  - While busy, cfg_ready=0. Config is ignored, not queued.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - start=1 and inc_reg!=0 -> RUN; acc<=0, per_cnt<=0.
  - start with inc_reg==0 is ignored (stays IDLE).
  - stop is ignored.
  - start and cfg_valid on the same edge: config is latched, and start uses the OLD inc_reg for the zero check. The new inc applies from the first step.
- RUN: each clock {carry, acc_next} = acc + inc_reg (ACC_W+1 bits). The first valid sample after start is index 0. On carry (period wrap):
  - If cycles_reg!=0 and per_cnt+1==cycles_reg: go to IDLE, acc<=0 (not the wrapped value), wave_done=1 for the next cycle.
  - Otherwise: per_cnt<=per_cnt+1 (wraps mod 2^CNT_W in continuous mode), acc<=acc_next.
- RUN, stop=1 without carry: -> STOPPING; acc still advances that edge.
- RUN, stop=1 and carry on the same edge: terminate -> IDLE, acc<=0, wave_done pulse. The period count is irrelevant here.
- STOPPING: acc keeps advancing. On the next carry -> IDLE, acc<=0, wave_done pulse. start and stop are ignored.
- start in RUN/STOPPING is ignored.
- wave_done is a registered pulse, high the first IDLE cycle after a normal or graceful end. It is never asserted on reset.
- Samples per period = ceil(2^ACC_W / inc_reg). For ACC_W=16, inc=1024 this is exactly 64 samples, indices 0..63.

Decomposition:
- Shared header file (sine_gen_defs) holds:
  - state encodings IDLE=2'd0, RUN=2'd1, STOPPING=2'd2
  - LUT_IDX_W=6
  - midscale index 6'd0
- Shared with other sine-generator blocks.
- One natural sub-module: phase_accumulator. It holds the registered ACC_W accumulator with clear, enable and increment inputs, and outputs acc and carry. The FSM, period counter and handshake stay in sine_phase_sequencer.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> cfg_ready=1, busy=0, lut_idx=0, sample_valid=0, wave_done=0.
- Finite run: cfg_inc=1024, cfg_cycles=2, start pulse -> 128 consecutive sample_valid cycles with lut_idx 0..63, 0..63. Then one wave_done pulse, busy=0, lut_idx=0.
- Graceful stop: cfg_inc=3000, cfg_cycles=0, start, stop pulse at sample 10 -> sample_valid continues to sample 21 (last acc=63000). On the next edge, IDLE with wave_done=1 and lut_idx=0.
- Stop coincident with wrap: cfg_inc=16384, cfg_cycles=0, stop asserted on the 4th sample (acc=49152) -> exactly 4 valid samples (idx 0, 16, 32, 48), then IDLE with wave_done; STOPPING is never entered.
- Config/start gating:
  - After reset, start with inc_reg=0 -> stays IDLE, no sample_valid.
  - During a run, cfg_valid with cfg_inc=5 -> cfg_ready=0, and the running rate is unchanged.
- Async reset mid-run: cfg_inc=1024, cfg_cycles=0, assert rst_n=0 at sample 20 -> within the same cycle sample_valid=0, lut_idx=0, busy=0, and no wave_done afterwards.
